// File: rtl/arbitro_rr4.sv
// Four-way round-robin arbiter with per-grant hold limit; select/grant/valid are registered, one-edge req-to-grant latency.
// A release with requests pending hands over on the same edge, so valid never drops between back-to-back grants.
module arbitro_rr4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] selector,
  output logic [3:0] grant,
  output logic       valid
);

  localparam logic [3:0] CNT_MAX = 4'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] last;
  logic [1:0] last_nxt;
  logic [1:0] selector_nxt;
  logic [1:0] winner;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [3:0] grant_nxt;
  logic       rel;

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] idx;
    rr_pick = from;
    // Scan from the far end so the nearest requester after 'from' wins.
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner = rr_pick(req, last);
  assign rel    = done | ~req[selector] | (cnt == CNT_MAX);
  assign valid  = (state == GRANT);

  always_comb begin
    state_nxt    = state;
    selector_nxt = selector;
    last_nxt     = last;
    cnt_nxt      = cnt;
    grant_nxt    = grant;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt    = GRANT;
          selector_nxt = winner;
          last_nxt     = winner;
          cnt_nxt      = 4'd0;
          grant_nxt    = 4'b0001 << winner;
        end
      end
      GRANT: begin
        if (rel) begin
          if (|req) begin
            selector_nxt = winner;
            last_nxt     = winner;
            cnt_nxt      = 4'd0;
            grant_nxt    = 4'b0001 << winner;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            grant_nxt = 4'b0000;
          end
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
      end
    endcase
  end

  // last resets to 3 so the first search after reset begins at index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      selector <= 2'd0;
      last     <= 2'd3;
      cnt      <= 4'd0;
      grant    <= 4'b0000;
    end else begin
      state    <= state_nxt;
      selector <= selector_nxt;
      last     <= last_nxt;
      cnt      <= cnt_nxt;
      grant    <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_arbitro_rr4.sv
// Bench for arbitro_rr4: cycle model of the round-robin rules plus directed scenarios with literal expectations.
module tb_arbitro_rr4;

  localparam int HOLD = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic       done  = 1'b0;
  logic [1:0] selector;
  logic [3:0] grant;
  logic       valid;

  int checks = 0;
  int errors = 0;

  // Downstream 4:1 mux driven by the arbiter's select.
  logic [7:0] din [4];
  logic [7:0] mux_out;
  initial begin
    din[0] = 8'hA0; din[1] = 8'hB1; din[2] = 8'hC2; din[3] = 8'hD3;
  end
  assign mux_out = din[selector];

  arbitro_rr4 #(.HOLD_MAX(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .selector (selector),
    .grant    (grant),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: who holds the grant, for how many cycles so far, and who was served last.
  bit m_busy = 1'b0;
  int m_idx  = 0;
  int m_last = 3;
  int m_held = 0;

  function automatic int rr_next(input logic [3:0] r, input int from);
    for (int off = 1; off <= 4; off++)
      if (r[(from + off) % 4]) return (from + off) % 4;
    return from;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_idx = 0; m_last = 3; m_held = 0;
    end else if (!m_busy || done || !req[m_idx] || m_held == HOLD) begin
      if (req != 4'b0000) begin
        m_idx  = rr_next(req, m_last);
        m_last = m_idx;
        m_held = 1;
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      m_held++;
    end
  end

  always @(negedge clk) begin
    chk("valid", valid, m_busy);
    chk("selector", selector, m_idx);
    chk("grant", grant, m_busy ? (32'd1 << m_idx) : 32'd0);
    if (m_busy) chk("mux_out", mux_out, din[m_idx]);
  end

  // Apply inputs just after an edge; return just after the next edge.
  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [1:0] s, input logic [3:0] g);
    chk({name, "_valid"}, valid, v);
    chk({name, "_sel"}, selector, s);
    chk({name, "_grant"}, grant, g);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 2'd0, 4'b0000);
    reset = 1'b0;

    // Everyone requesting, done on every third cycle: 0,1,2,3,0.
    step(4'b1111, 1'b0);
    expect_out("rr_first", 1'b1, 2'd0, 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
      chk("rr_seq", selector, 32'(i % 4));
    end
    step(4'b0000, 1'b0);
    expect_out("rr_idle", 1'b0, 2'd0, 4'b0000);

    // Lone requester hits the hold limit and is re-granted.
    for (int j = 0; j < HOLD; j++) begin
      step(4'b0100, 1'b0);
      chk("hold_grant", grant, 4'b0100);
    end
    step(4'b0100, 1'b0);
    expect_out("regrant", 1'b1, 2'd2, 4'b0100);
    for (int j = 1; j < HOLD; j++) begin
      step(4'b0110, 1'b0);
      chk("hold_restart", selector, 2'd2);
    end
    step(4'b0110, 1'b0);
    expect_out("hold_handover", 1'b1, 2'd1, 4'b0010);

    // Drop to idle keeps selector; done in idle ignored; search resumes after 1.
    step(4'b0000, 1'b0);
    expect_out("drop_idle", 1'b0, 2'd1, 4'b0000);
    step(4'b0000, 1'b1);
    expect_out("done_in_idle", 1'b0, 2'd1, 4'b0000);
    step(4'b0001, 1'b0);
    expect_out("wrap_to_0", 1'b1, 2'd0, 4'b0001);

    // Grant on 3, then done and req[3] drop together: one release to 1.
    step(4'b1000, 1'b0);
    expect_out("to_3", 1'b1, 2'd3, 4'b1000);
    step(4'b1010, 1'b0);
    expect_out("hold_3", 1'b1, 2'd3, 4'b1000);
    step(4'b0010, 1'b1);
    expect_out("double_rel", 1'b1, 2'd1, 4'b0010);

    // Asynchronous reset mid-grant on 2.
    step(4'b0100, 1'b0);
    expect_out("to_2", 1'b1, 2'd2, 4'b0100);
    step(4'b0100, 1'b0);
    #1 reset = 1'b1;
    #1 expect_out("async_rst", 1'b0, 2'd0, 4'b0000);
    reset = 1'b0;
    step(4'b0101, 1'b0);
    expect_out("post_rst", 1'b1, 2'd0, 4'b0001);

    // Deterministic mixed pattern, checked by the model every cycle.
    for (int i = 0; i < 300; i++)
      step(4'((i * 5 + 3) ^ (i >> 2)), (i % 7) == 3);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    expect_out("final_idle", 1'b0, 2'(m_idx), 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_rr4.md
ARBITRO_RR4 -- requirements
Module: arbitro_rr4

Interface
REQ-001 Parameter HOLD_MAX, default 8, maximum consecutive cycles one requester SHALL hold a grant; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; one clock and asynchronous active-high reset, fixed.
REQ-004 req  input  4  request lines; bit i corresponds to mux data input A/B/C/D for i = 0/1/2/3.
REQ-005 done  input  1  consumer pulse; ends the current grant in the cycle it is sampled high.
REQ-006 selector  output  2  registered index of the granted requester; drives the downstream 4:1 mux select.
REQ-007 grant  output  4  registered one-hot grant, equal to (1 << selector) when valid=1, else 0.
REQ-008 valid  output  1  registered; high while a grant is active and mux output is meaningful.

Function
REQ-009 The block SHALL be a two-state FSM: IDLE (valid=0, grant=0) and GRANT (valid=1).
REQ-010 A pointer last[1:0] SHALL record the most recently granted index; search order SHALL be last+1, last+2, last+3, last (mod 4).
REQ-011 In IDLE with req!=0 sampled at edge N, the FSM SHALL enter GRANT at edge N with selector = first requester in search order; latency one edge, no combinational req-to-grant path.
REQ-012 In IDLE with req==0, selector SHALL hold its previous value and last SHALL not change.
REQ-013 Entering GRANT SHALL load last = new selector and clear hold counter cnt to 0.
REQ-014 In GRANT, cnt SHALL increment by 1 per cycle, saturating at HOLD_MAX-1.
REQ-015 Release condition in GRANT: done=1, OR req[selector]=0, OR cnt==HOLD_MAX-1; any combination SHALL be treated as one release.
REQ-016 On release, if any req bit is set the FSM SHALL stay in GRANT and switch directly to the next winner per REQ-010 with no idle bubble (valid stays 1).
REQ-017 On release with req==0, the FSM SHALL go to IDLE at that edge (valid=0, grant=0).
REQ-018 If the releasing requester is the only one requesting, it SHALL be re-granted (same selector, cnt cleared, valid stays 1).
REQ-019 Without a release, selector, grant and last SHALL remain stable regardless of other req changes.
REQ-020 done sampled in IDLE SHALL be ignored.
REQ-021 grant SHALL never have more than one bit set; selector SHALL change only on an edge where a new grant is issued.

Reset
REQ-022 reset high SHALL immediately (asynchronously) force IDLE, selector=0, grant=0, valid=0, cnt=0, last=3 so the first search starts at index 0.
REQ-023 reset asserted mid-grant SHALL abort the grant with no completion; after release, first grant SHALL follow REQ-011 from last=3.
REQ-024 The first rising edge after reset deasserts SHALL be able to issue a grant.

Verification
REQ-025 Reset, then req=4'b1111 held, done pulsed each 3rd cycle -> selector sequence 0,1,2,3,0, valid continuously 1 after first grant.
REQ-026 req=4'b0100 held, done=0, HOLD_MAX=8 -> grant=4'b0100 for 8 cycles, re-granted to 2 (cnt restarts), valid never drops.
REQ-027 Grant on 1, then req=4'b0000 -> next edge valid=0, grant=0, selector stays 1; then req=4'b0001 -> selector=2? no: search from 2 finds 0, selector=0.
REQ-028 Grant on 3 with req=4'b1010, done and req[3] drop in same cycle -> single release, next selector=1.
REQ-029 reset pulsed asynchronously between edges during grant on 2 -> outputs 0 before next edge; req=4'b0101 afterwards -> selector=0.
REQ-030 Every cycle: grant one-hot or zero, grant==(1<<selector) when valid=1, downstream mux output equals the selected data input.
